// File: rtl/mult8_shift_add_ctrl.sv
// Control FSM and register stage for the 8-bit signed shift-add multiplier.
// Owns the X/A/B/S registers; the 9-bit add/subtract stage lives outside and is driven from here.
module mult8_shift_add_ctrl #(
  parameter int N_BITS = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              ClearA_LoadB,
  input  logic [N_BITS-1:0] Switches,
  input  logic [N_BITS-1:0] sum_i,
  input  logic              x_i,
  output logic              add_o,
  output logic              sub_o,
  output logic [N_BITS-1:0] adder_a_o,
  output logic [N_BITS-1:0] adder_s_o,
  output logic [N_BITS-1:0] Aval,
  output logic [N_BITS-1:0] Bval,
  output logic              X,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(N_BITS);
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [N_BITS-1:0] a_reg, b_reg, s_reg;
  logic              x_reg;
  logic [CW-1:0]     cnt;
  logic              run_q;
  logic              rise;

  assign rise = Run & ~run_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= Run;
    end
  end

  // Load has priority over a start request in IDLE; the last iteration subtracts
  // because the multiplier MSB carries negative weight.
  always_comb begin
    state_nxt = state;
    add_o     = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!ClearA_LoadB && rise) state_nxt = S_CLR;
      end
      S_CLR: begin
        busy      = 1'b1;
        state_nxt = S_ADD;
      end
      S_ADD: begin
        busy      = 1'b1;
        add_o     = (cnt != LAST);
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy      = 1'b1;
        state_nxt = (cnt == LAST) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        done = 1'b1;
        if (!Run) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      x_reg <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ClearA_LoadB) begin
            a_reg <= '0;
            x_reg <= 1'b0;
            b_reg <= Switches;
          end
        end
        S_CLR: begin
          a_reg <= '0;
          x_reg <= 1'b0;
          s_reg <= Switches;
          cnt   <= '0;
        end
        S_ADD: begin
          if (b_reg[0]) begin
            x_reg <= x_i;
            a_reg <= sum_i;
          end
        end
        S_SHIFT: begin
          a_reg <= {x_reg, a_reg[N_BITS-1:1]};
          b_reg <= {a_reg[0], b_reg[N_BITS-1:1]};
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sub_o     = ~add_o;
  assign adder_a_o = a_reg;
  assign adder_s_o = s_reg;
  assign Aval      = a_reg;
  assign Bval      = b_reg;
  assign X         = x_reg;

endmodule
